// File: rtl/common.sv
// Shared cbus types between the caches, the arbiter and the memory bridge.
package common;

    typedef enum logic [2:0] {
        MSIZE1 = 3'b000,
        MSIZE2 = 3'b001,
        MSIZE4 = 3'b010,
        MSIZE8 = 3'b011
    } msize_t;

    // Encoded as beats-1, so the field doubles as the final beat index.
    typedef enum logic [3:0] {
        MLEN1  = 4'b0000,
        MLEN2  = 4'b0001,
        MLEN4  = 4'b0011,
        MLEN8  = 4'b0111,
        MLEN16 = 4'b1111
    } mlen_t;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        mlen_t       len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    function automatic logic [4:0] len_to_beats(mlen_t len);
        case (len)
            MLEN1:   return 5'd1;
            MLEN2:   return 5'd2;
            MLEN4:   return 5'd4;
            MLEN8:   return 5'd8;
            MLEN16:  return 5'd16;
            default: return 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first valid index after last_grant, wrapping.
module rr_picker #(
    parameter int NUM_MASTERS = 2,
    parameter int SEL_BITS    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic [NUM_MASTERS-1:0] valid,
    input  logic [SEL_BITS-1:0]    last_grant,
    output logic                   found,
    output logic [SEL_BITS-1:0]    idx
);

    logic [SEL_BITS-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        // Offset NUM_MASTERS wraps back to last_grant itself, so it is tried last.
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = SEL_BITS'((int'(last_grant) + k) % NUM_MASTERS);
            if (!found && valid[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// Round-robin merge of the cache cbus masters onto the single memory cbus,
// grant held for a whole burst, with beat-count versus len checking.
module cbus_rr_arbiter
    import common::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int SEL_BITS    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  cbus_req_t  [NUM_MASTERS-1:0]  ireqs,
    output cbus_resp_t [NUM_MASTERS-1:0]  iresps,
    output cbus_req_t                     oreq,
    input  cbus_resp_t                    oresp,
    output logic                          busy,
    output logic [SEL_BITS-1:0]           grant_idx,
    output logic                          len_err
);

    arb_state_t          state, state_nx;
    logic [SEL_BITS-1:0] sel, last_grant, pick_idx;
    logic [3:0]          beat_cnt;
    logic [NUM_MASTERS-1:0] req_vld;
    logic                found;
    logic [4:0]          final_idx;
    logic                at_final;

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) req_vld[i] = ireqs[i].valid;
    end

    rr_picker #(
        .NUM_MASTERS(NUM_MASTERS),
        .SEL_BITS   (SEL_BITS)
    ) u_picker (
        .valid     (req_vld),
        .last_grant(last_grant),
        .found     (found),
        .idx       (pick_idx)
    );

    assign final_idx = len_to_beats(ireqs[sel].len) - 5'd1;
    assign at_final  = ({1'b0, beat_cnt} == final_idx);
    assign grant_idx = (state == ARB_BUSY) ? sel : last_grant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ARB_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        oreq     = '0;
        iresps   = '0;
        busy     = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (found) state_nx = ARB_BUSY;
            end
            ARB_BUSY: begin
                // Pass-through even if the master drops valid mid-burst.
                oreq        = ireqs[sel];
                iresps[sel] = oresp;
                busy        = 1'b1;
                if (oresp.ready && oresp.last) state_nx = ARB_IDLE;
            end
            default: state_nx = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel        <= '0;
            last_grant <= SEL_BITS'(NUM_MASTERS - 1);
            beat_cnt   <= '0;
            len_err    <= 1'b0;
        end else if (state == ARB_IDLE) begin
            if (found) begin
                sel      <= pick_idx;
                beat_cnt <= '0;
            end
        end else if (oresp.ready) begin
            beat_cnt <= beat_cnt + 4'd1;
            if (oresp.last) begin
                last_grant <= sel;
                if (!at_final) len_err <= 1'b1;
            end else if (at_final) begin
                // Final beat by len arrived without last; keep waiting for last.
                len_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/cbus_rr_arbiter.md
Name: cbus_rr_arbiter

Overview:
- Downstream neighbour of the instruction and data caches. Merges NUM_MASTERS cbus request streams (ICache, DCache) onto the single cbus toward the memory/AXI bridge.
- Round-robin fairness, one-cycle arbitration latency, grant locked for a whole burst until the last beat is accepted.
- Steers the response only to the granted master.
- Counts beats and flags a response whose `last` disagrees with the requested `len`.

Parameters:
- NUM_MASTERS, 2, number of upstream cbus masters; index 0 = ICache, 1 = DCache.
- SEL_BITS, $clog2(NUM_MASTERS) (min 1), width of the grant index.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 clears all state immediately).
- ireqs  input  NUM_MASTERS x cbus_req_t  upstream requests (valid, is_write, size, addr, strobe, data, len, burst).
- iresps  output  NUM_MASTERS x cbus_resp_t  upstream responses (ready, last, data).
- oreq  output  cbus_req_t  request to memory bridge.
- oresp  input  cbus_resp_t  response from memory bridge.
- busy  output  1  a granted transaction is in flight.
- grant_idx  output  SEL_BITS  index of the current or last granted master.
- len_err  output  1  sticky: a beat-count/last mismatch has been detected.

Behaviour:
- Reset values (asserted asynchronously while reset==0):
  - state=IDLE, last_grant=NUM_MASTERS-1 so master 0 wins first, beat_cnt=0, len_err=0.
  - oreq all-zero, every iresps all-zero, busy=0.
- States:
  - IDLE: oreq='0 and iresps='0. If any ireqs[i].valid, choose the first valid index scanning last_grant+1, last_grant+2, ... modulo NUM_MASTERS. Register it as sel, set beat_cnt=0 and go to BUSY. No valid request: stay in IDLE.
  - BUSY: oreq=ireqs[sel] passed through combinationally. iresps[sel]=oresp, all other iresps='0, busy=1.
    - On each cycle with oresp.ready, increment beat_cnt.
    - On oresp.ready && oresp.last: last_grant<=sel and return to IDLE next cycle.
- Latency: a request valid in cycle N appears on oreq in cycle N+1. Back-to-back transactions have one IDLE bubble between them.
- Fairness: after a master completes, every other waiting master is served before it is served again. With both masters requesting continuously, grants alternate 0,1,0,1.
- Beat check, on the beat with oresp.ready && oresp.last:
  - If beat_cnt != number of beats encoded by oreq.len minus 1, set len_err=1 (sticky until reset). mlen_t beats: MLEN1=1, MLEN2=2, MLEN4=4, MLEN8=8, MLEN16=16.
  - If beat_cnt reaches the encoded beat count without last, also set len_err. The arbiter still waits for last.
  - beat_cnt is 4 bits wide and wraps modulo 16.
- Simultaneous events:
  - A new request arriving on the same cycle as last: it is not granted that cycle. It is arbitrated in the following IDLE cycle.
  - Two requests arriving in the same cycle: round-robin order decides.
- Master drops valid while BUSY (protocol violation): the grant is held and oreq.valid follows the master (0). The arbiter stays BUSY until oresp.last. No other master may be granted mid-burst.
- Reset mid-burst: all outputs go to zero asynchronously and state returns to IDLE. The memory bridge shares the same reset.
- grant_idx = sel in BUSY, last_grant in IDLE.

Decomposition:
- Package common already holds cbus_req_t, cbus_resp_t, mlen_t, msize_t, and AXI_BURST_*.
- Add to common:
  - arb_state_t enum {ARB_IDLE, ARB_BUSY}.
  - Function len_to_beats(mlen_t) returning a 5-bit beat count.
- One combinational sub-module, rr_picker (inputs: valid vector, last_grant; outputs: found, idx). It is reused by any future N-way arbiter.

Test Plan:
- Reset release, ireqs[1] valid (read, MLEN16, addr 0x8000_0040), memory returns 16 ready beats with last on beat 16 -> oreq.valid rises 1 cycle after request; iresps[1] sees all 16 beats; iresps[0] stays 0; len_err=0.
- Both masters valid continuously with MLEN1 reads, 6 transactions -> grant order 0,1,0,1,0,1 with one IDLE cycle between grants.
- DCache MLEN16 writeback in flight while ICache raises valid on beat 5 -> ICache receives nothing until DCache's last beat; ICache is granted 1 cycle after DCache returns to IDLE.
- MLEN4 request, memory asserts last on beat 3 -> len_err=1 and remains 1 through later correct transactions until reset.
- reset driven to 0 at beat 7 of an MLEN16 burst, asynchronously between clock edges -> oreq.valid=0 and busy=0 immediately without a clock edge; after release master 0 has priority.
- Master 0 deasserts valid at beat 2 of MLEN8 while master 1 is waiting -> no grant to master 1 until oresp.last; then master 1 is granted next arbitration cycle.
